// File: rtl/test_ram_if.sv
// test_ram_if: CPU req/ack byte memory handshake between core (master) and RAM responder (slave)
interface test_ram_if #(
    parameter int BUS_ADDR_WIDTH = 24,
    parameter int DATA_WIDTH     = 8
);
    logic                      req;
    logic                      we;
    logic [BUS_ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0]     wdata;
    logic [DATA_WIDTH-1:0]     rdata;
    logic                      ack;
    logic                      err;
    logic                      busy;

    modport master (output req, we, addr, wdata, input rdata, ack, err, busy);
    modport slave  (input req, we, addr, wdata, output rdata, ack, err, busy);
endinterface

// File: rtl/test_ram_responder.sv
// test_ram_responder: on-chip test RAM answering CPU byte requests with configurable wait states
module test_ram_responder #(
    parameter int BUS_ADDR_WIDTH = 24,
    parameter int RAM_ADDR_WIDTH = 16,
    parameter int DATA_WIDTH     = 8,
    parameter int WAIT_STATES    = 1
) (
    input logic       clk,
    input logic       rst,
    test_ram_if.slave bus
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] WAIT    = 2'd1;
    localparam logic [1:0] RESPOND = 2'd2;
    localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES - 1);

    logic [1:0]                state, state_nx;
    logic [3:0]                cnt;
    logic [RAM_ADDR_WIDTH-1:0] l_idx, eff_idx;
    logic                      l_we, eff_we;
    logic                      l_ok, eff_ok;
    logic [DATA_WIDTH-1:0]     l_wdata, eff_wdata;
    logic                      range_ok;
    logic                      accept;
    logic                      enter;
    logic [DATA_WIDTH-1:0]     mem [2**RAM_ADDR_WIDTH];

    assign range_ok = (bus.addr >> RAM_ADDR_WIDTH) == '0;
    assign accept   = state == IDLE && bus.req;
    assign enter    = state_nx == RESPOND;

    // next state; with zero wait states the request edge is also the RESPOND-entry edge,
    // so the effective access fields bypass the latch while still in IDLE
    always_comb begin
        state_nx  = state == IDLE ? (bus.req ? (WAIT_STATES == 0 ? RESPOND : WAIT) : IDLE) :
                    state == WAIT ? (cnt == '0 ? RESPOND : WAIT) : IDLE;
        eff_idx   = state == IDLE ? bus.addr[RAM_ADDR_WIDTH-1:0] : l_idx;
        eff_we    = state == IDLE ? bus.we : l_we;
        eff_ok    = state == IDLE ? range_ok : l_ok;
        eff_wdata = state == IDLE ? bus.wdata : l_wdata;
    end

    // control FSM, wait counter, registered outputs and request latch
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bus.ack   <= 1'b0;
            bus.err   <= 1'b0;
            bus.busy  <= 1'b0;
            bus.rdata <= '0;
        end else begin
            state    <= state_nx;
            bus.ack  <= enter;
            bus.err  <= enter && !eff_ok;
            bus.busy <= state_nx != IDLE;
            if (accept) begin
                cnt     <= WS_LOAD;
                l_idx   <= bus.addr[RAM_ADDR_WIDTH-1:0];
                l_we    <= bus.we;
                l_ok    <= range_ok;
                l_wdata <= bus.wdata;
            end else if (state == WAIT && cnt != '0) begin
                cnt <= cnt - 4'd1;
            end
            if (enter && !eff_we)
                bus.rdata <= eff_ok ? mem[eff_idx] : '1;
        end
    end

    // RAM write port; contents survive reset but reset blocks a commit on the same edge
    always_ff @(posedge clk) begin
        if (!rst && enter && eff_we && eff_ok)
            mem[eff_idx] <= eff_wdata;
    end
endmodule

// File: tb/tb_test_ram_responder.sv
// tb_test_ram_responder: table + scoreboard checks of four responders with 0..3 wait states
module tb_test_ram_responder;
    typedef struct {
        int          d;
        bit          w;
        logic [23:0] a;
        logic [7:0]  wd;
        logic [7:0]  rd;
        logic        err;
    } vec_t;

    typedef struct {
        logic [7:0] rdata;
        logic       err;
        int         lat;
    } exp_t;

    logic        clk = 0;
    logic        rst_v   [4];
    logic        req_v   [4];
    logic        we_v    [4];
    logic [23:0] addr_v  [4];
    logic [7:0]  wdata_v [4];
    logic [7:0]  rdata_v [4];
    logic        ack_v   [4];
    logic        err_v   [4];
    logic        busy_v  [4];

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    vec_t tbl[16];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : gen_dut
        test_ram_if #(.BUS_ADDR_WIDTH(24), .DATA_WIDTH(8)) bus ();
        assign bus.req     = req_v[g];
        assign bus.we      = we_v[g];
        assign bus.addr    = addr_v[g];
        assign bus.wdata   = wdata_v[g];
        assign rdata_v[g]  = bus.rdata;
        assign ack_v[g]    = bus.ack;
        assign err_v[g]    = bus.err;
        assign busy_v[g]   = bus.busy;
        test_ram_responder #(
            .BUS_ADDR_WIDTH(24),
            .RAM_ADDR_WIDTH(16),
            .DATA_WIDTH(8),
            .WAIT_STATES(g)
        ) dut (
            .clk(clk),
            .rst(rst_v[g]),
            .bus(bus)
        );
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic txn(input int d, input bit w, input logic [23:0] a, input logic [7:0] wd,
                       input logic [7:0] er, input logic ee);
        exp_t e;
        int   n;
        @(posedge clk); #1;
        req_v[d] = 1; we_v[d] = w; addr_v[d] = a; wdata_v[d] = wd;
        e.rdata = er; e.err = ee; e.lat = d + 1;
        exp_q.push_back(e);
        n = 0;
        while (n < 20) begin
            @(posedge clk); #1;
            n++;
            if (ack_v[d]) break;
        end
        req_v[d] = 0;
        e = exp_q.pop_front();
        chk($sformatf("latency d%0d @%06h", d, a), n, e.lat);
        chk($sformatf("rdata d%0d @%06h", d, a), {24'd0, rdata_v[d]}, {24'd0, e.rdata});
        chk($sformatf("err d%0d @%06h", d, a), {31'd0, err_v[d]}, {31'd0, e.err});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{1, 1, 24'h001234, 8'hA5, 8'h00, 1'b0};
        tbl[1]  = '{1, 0, 24'h001234, 8'h00, 8'hA5, 1'b0};
        tbl[2]  = '{1, 1, 24'hFFFFFF, 8'h99, 8'hA5, 1'b1};
        tbl[3]  = '{1, 0, 24'h001234, 8'h00, 8'hA5, 1'b0};
        tbl[4]  = '{0, 1, 24'h000000, 8'h11, 8'h00, 1'b0};
        tbl[5]  = '{0, 1, 24'h00FFFF, 8'h22, 8'h00, 1'b0};
        tbl[6]  = '{0, 0, 24'h000000, 8'h00, 8'h11, 1'b0};
        tbl[7]  = '{0, 0, 24'h00FFFF, 8'h00, 8'h22, 1'b0};
        tbl[8]  = '{0, 1, 24'h010000, 8'h5A, 8'h22, 1'b1};
        tbl[9]  = '{0, 0, 24'h000000, 8'h00, 8'h11, 1'b0};
        tbl[10] = '{0, 0, 24'h7F0000, 8'h00, 8'hFF, 1'b1};
        tbl[11] = '{0, 1, 24'h000001, 8'h44, 8'hFF, 1'b0};
        tbl[12] = '{2, 1, 24'h000040, 8'h33, 8'h00, 1'b0};
        tbl[13] = '{3, 1, 24'h000010, 8'hC3, 8'h00, 1'b0};
        tbl[14] = '{3, 1, 24'h000020, 8'h3C, 8'h00, 1'b0};
        tbl[15] = '{2, 0, 24'h000040, 8'h00, 8'h33, 1'b0};

        for (int i = 0; i < 4; i++) begin
            rst_v[i] = 1; req_v[i] = 0; we_v[i] = 0; addr_v[i] = '0; wdata_v[i] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            rst_v[i] = 0;
            chk($sformatf("reset ack d%0d", i), {31'd0, ack_v[i]}, 0);
            chk($sformatf("reset err d%0d", i), {31'd0, err_v[i]}, 0);
            chk($sformatf("reset busy d%0d", i), {31'd0, busy_v[i]}, 0);
            chk($sformatf("reset rdata d%0d", i), {24'd0, rdata_v[i]}, 0);
        end

        for (int i = 0; i < 16; i++)
            txn(tbl[i].d, tbl[i].w, tbl[i].a, tbl[i].wd, tbl[i].rd, tbl[i].err);

        // latched address wins over a live change; busy spans cycles 1..4
        @(posedge clk); #1;
        req_v[3] = 1; we_v[3] = 0; addr_v[3] = 24'h000010;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk); #1;
            chk($sformatf("ws3 busy c%0d", c), {31'd0, busy_v[3]}, (c <= 4) ? 1 : 0);
            chk($sformatf("ws3 ack c%0d", c), {31'd0, ack_v[3]}, (c == 4) ? 1 : 0);
            if (c == 1) addr_v[3] = 24'h000020;
            if (c == 4) begin
                chk("ws3 latched rdata", {24'd0, rdata_v[3]}, 32'hC3);
                req_v[3] = 0;
            end
        end

        // reset coinciding with the RESPOND-entry edge drops the write
        @(posedge clk); #1;
        req_v[2] = 1; we_v[2] = 1; addr_v[2] = 24'h000040; wdata_v[2] = 8'h77;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_v[2] = 1;
        @(posedge clk); #1;
        rst_v[2] = 0; req_v[2] = 0;
        chk("rst mid ack", {31'd0, ack_v[2]}, 0);
        chk("rst mid busy", {31'd0, busy_v[2]}, 0);
        chk("rst mid rdata", {24'd0, rdata_v[2]}, 0);
        @(posedge clk); #1;
        chk("rst mid ack after", {31'd0, ack_v[2]}, 0);
        txn(2, 0, 24'h000040, 8'h00, 8'h33, 1'b0);

        // req held through ack: no restart in RESPOND, restart from the following IDLE cycle
        @(posedge clk); #1;
        req_v[1] = 1; we_v[1] = 0; addr_v[1] = 24'h001234;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk); #1;
            chk($sformatf("held ack c%0d", c), {31'd0, ack_v[1]}, (c == 2 || c == 5) ? 1 : 0);
            if (c == 5) begin
                chk("held rdata", {24'd0, rdata_v[1]}, 32'hA5);
                req_v[1] = 0;
            end
        end

        // req dropped after one cycle: transaction still acks and the write commits
        @(posedge clk); #1;
        req_v[3] = 1; we_v[3] = 1; addr_v[3] = 24'h000030; wdata_v[3] = 8'h55;
        @(posedge clk); #1;
        req_v[3] = 0; addr_v[3] = 24'h000000; wdata_v[3] = 8'h00;
        for (int c = 2; c <= 5; c++) begin
            @(posedge clk); #1;
            chk($sformatf("drop ack c%0d", c), {31'd0, ack_v[3]}, (c == 4) ? 1 : 0);
        end
        txn(3, 0, 24'h000030, 8'h00, 8'h55, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/test_ram_responder.md
Name: test_ram_responder

Overview:
- Bus-responder side of the CPU memory interface: services the 65c816 core's byte read/write requests from an on-chip test RAM.
- Models configurable wait states and flags accesses outside the implemented RAM.
- Sits between the CPU top level and simulation/FPGA test harnesses; it is the slave end of the CPU's req/ack memory handshake.

Parameters:
- BUS_ADDR_WIDTH, 24, CPU address width (bank:address).
- RAM_ADDR_WIDTH, 16, implemented RAM depth = 2^RAM_ADDR_WIDTH bytes; must be <= BUS_ADDR_WIDTH.
- DATA_WIDTH, 8, bus data width.
- WAIT_STATES, 1, extra cycles inserted before ack; range 0..15.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  1  CPU request; held high with addr/we/wdata stable until ack is seen.
- we  in  1  1 = write, 0 = read; sampled with req.
- addr  in  BUS_ADDR_WIDTH  byte address.
- wdata  in  DATA_WIDTH  write data.
- rdata  out  DATA_WIDTH  read data; valid in the ack cycle of a read.
- ack  out  1  one-cycle completion pulse.
- err  out  1  high with ack when the access was out of range.
- busy  out  1  high while a transaction is in progress (not IDLE).

Behaviour:
- Reset (synchronous): state=IDLE, ack=0, err=0, busy=0, rdata=0, wait counter=0. RAM contents are not cleared and are preserved across reset.
- FSM states: IDLE, WAIT, RESPOND.
- IDLE, req=1 at edge k:
  - Latch addr/we/wdata into internal registers.
  - range_ok = (addr >> RAM_ADDR_WIDTH) == 0.
  - If WAIT_STATES=0, go to RESPOND. Otherwise load counter=WAIT_STATES-1 and go to WAIT.
- WAIT: decrement counter each cycle. Leave for RESPOND on the edge where counter==0.
- Transition into RESPOND (same edge):
  - Read: rdata <= RAM[latched addr low bits] if range_ok, else all-ones (0xFF).
  - Write: RAM written if range_ok, otherwise discarded; rdata unchanged.
- RESPOND: ack=1 and err=!range_ok for exactly one cycle, then IDLE unconditionally.
- Latency: with req first high in cycle 0, ack is high in cycle WAIT_STATES+1. WAIT_STATES=0 gives ack in cycle 1.
- req while busy: ignored. Live addr/we/wdata changes after latch have no effect; the latched values are used.
- req still high in the RESPOND cycle: not a new request. req high in the cycle after ack (IDLE) starts a new transaction. Maximum throughput is one access per WAIT_STATES+2 cycles.
- req dropped mid-transaction (protocol violation): transaction still completes and acks; the write still commits.
- rdata holds its value between reads; writes do not change it.
- ack, err, busy are registered (no combinational path from req).
- Reset mid-transaction: return to IDLE, no ack.
  - A write whose RESPOND-entry edge coincides with rst=1 is not committed; rst has priority over all updates.
- Address mapping: RAM index = addr[RAM_ADDR_WIDTH-1:0]. Out-of-range addresses never alias.
- busy = (state != IDLE).

Test Plan:
- WAIT_STATES=1: write 0xA5 to 0x001234, then read 0x001234 -> each ack exactly 2 cycles after req rises; read rdata=0xA5, err=0.
- WAIT_STATES=0, back-to-back requests: write 0x11@0x0000, write 0x22@0xFFFF, read 0x0000, read 0xFFFF -> ack in cycle 1 of each; rdata 0x11 then 0x22; each next request accepted the cycle after ack.
- Out of range (RAM_ADDR_WIDTH=16): write 0x5A to 0x010000 -> ack+err=1, then read 0x000000 shows the prior value (no alias); read 0x7F0000 -> rdata=0xFF, err=1.
- WAIT_STATES=3, read at 0x000010, with addr changed to 0x000020 in cycle 1 -> ack in cycle 4, rdata = RAM[0x10], busy high cycles 1..4.
- Reset mid-write (WAIT_STATES=2): write 0x77@0x0040 after RAM[0x40]=0x33, rst pulsed in cycle 2 -> no ack, busy=0, rdata=0; subsequent read of 0x0040 returns 0x33.
- req held high across ack -> RESPOND cycle does not start a second transaction; with req still high in the next IDLE cycle a second ack follows WAIT_STATES+1 cycles later.
